// File: rtl/rgb_mixer_pkg.sv
// Shared definitions for the RGB mixer front end: channel width,
// quadrature phase encoding and the default debounce depth.
package rgb_mixer_pkg;

    localparam int LEVEL_W          = 8;
    localparam int DEBOUNCE_DEFAULT = 16;

    // Quadrature phase index; consecutive values are one sub-step apart
    // in the clockwise direction.
    typedef enum logic [1:0] {
        PH_00 = 2'd0,
        PH_10 = 2'd1,
        PH_11 = 2'd2,
        PH_01 = 2'd3
    } phase_t;

    // Map the debounced {A,B} pin pair onto its phase index.
    function automatic phase_t phase_of(input logic a, input logic b);
        phase_t ph;
        case ({a, b})
            2'b00:   ph = PH_00;
            2'b10:   ph = PH_10;
            2'b11:   ph = PH_11;
            default: ph = PH_01;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/input_debounce.sv
// Single-bit 2-flop synchronizer followed by a stable-level counter.
// The output only follows the synchronized input once it has differed
// from the accepted level for DEBOUNCE_CYCLES consecutive cycles.
module input_debounce
    import rgb_mixer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable
);

    localparam logic [7:0] LAST_COUNT = 8'(DEBOUNCE_CYCLES - 1);

    logic [1:0] sync_q;
    logic [7:0] count_q;

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

    // Count cycles of disagreement; accept the new level on the last one,
    // restart the count whenever the input agrees with the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
            stable  <= 1'b0;
        end else if (sync_q[1] == stable) begin
            count_q <= 8'd0;
        end else if (count_q == LAST_COUNT) begin
            count_q <= 8'd0;
            stable  <= sync_q[1];
        end else begin
            count_q <= count_q + 8'd1;
        end
    end

endmodule

// File: rtl/quad_encoder_counter.sv
// One rotary-encoder channel: debounced A/B pins feed a quadrature
// decoder whose detent events move an 8-bit level for the PWM stage.
// A detent is the clockwise 3->0 or counter-clockwise 0->3 phase step.
module quad_encoder_counter
    import rgb_mixer_pkg::*;
#(
    parameter int WIDTH           = LEVEL_W,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter bit SATURATE        = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             enc_a,
    input  logic             enc_b,
    output logic [WIDTH-1:0] value,
    output logic             step,
    output logic             dir,
    output logic             err
);

    localparam logic [WIDTH-1:0] VALUE_MAX = '1;

    logic       a_stable;
    logic       b_stable;
    logic [1:0] phase_q;
    logic [1:0] phase_cur;
    logic [1:0] delta;
    logic       illegal;
    logic       detent_up;
    logic       detent_down;
    logic [WIDTH-1:0] value_next;

    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (enc_a),
        .stable (a_stable)
    );

    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (enc_b),
        .stable (b_stable)
    );

    // Classify the move from the registered phase to the current phase.
    always_comb begin
        phase_cur   = phase_of(a_stable, b_stable);
        delta       = phase_cur - phase_q;
        illegal     = (delta == 2'd2);
        detent_up   = (delta == 2'd1) && (phase_q == PH_01);
        detent_down = (delta == 2'd3) && (phase_q == PH_00);
    end

    // Next level for a detent, clamped or wrapping at the range ends.
    always_comb begin
        value_next = value;
        if (detent_up) begin
            if (!(SATURATE && (value == VALUE_MAX))) begin
                value_next = value + 1'b1;
            end
        end else if (detent_down) begin
            if (!(SATURATE && (value == '0))) begin
                value_next = value - 1'b1;
            end
        end
    end

    // Phase tracking always runs (an illegal jump resynchronizes to the
    // current phase); level, step and dir only move while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_00;
            value   <= '0;
            step    <= 1'b0;
            dir     <= 1'b0;
            err     <= 1'b0;
        end else begin
            phase_q <= phase_cur;
            err     <= illegal;
            step    <= ena && (detent_up || detent_down);
            if (ena && (detent_up || detent_down)) begin
                dir   <= detent_up;
                value <= value_next;
            end
        end
    end

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Directed bench for quad_encoder_counter with DEBOUNCE_CYCLES=4.
// Two instances share the pins: one saturating, one wrapping.
module tb_quad_encoder_counter;

    localparam int HOLD = 10;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       enc_a;
    logic       enc_b;
    logic [7:0] value_s;
    logic       step_s;
    logic       dir_s;
    logic       err_s;
    logic [7:0] value_w;
    logic       step_w;
    logic       dir_w;
    logic       err_w;

    int checks;
    int errors;
    int step_cnt_s;
    int step_cnt_w;
    int err_cnt_s;
    int overlap_cnt;
    int wide_err_cnt;
    logic err_prev;

    quad_encoder_counter #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .ena(ena), .enc_a(enc_a), .enc_b(enc_b),
        .value(value_s), .step(step_s), .dir(dir_s), .err(err_s)
    );

    quad_encoder_counter #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .ena(ena), .enc_a(enc_a), .enc_b(enc_b),
        .value(value_w), .step(step_w), .dir(dir_w), .err(err_w)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitors, sampled on the falling edge
    initial begin
        step_cnt_s = 0; step_cnt_w = 0; err_cnt_s = 0;
        overlap_cnt = 0; wide_err_cnt = 0; err_prev = 1'b0;
    end
    always @(negedge clk) begin
        if (step_s === 1'b1) step_cnt_s++;
        if (step_w === 1'b1) step_cnt_w++;
        if (err_s === 1'b1) err_cnt_s++;
        if (step_s === 1'b1 && err_s === 1'b1) overlap_cnt++;
        if (err_s === 1'b1 && err_prev === 1'b1) wide_err_cnt++;
        err_prev = err_s;
    end

    // Driver tasks: all start and end one time unit after a rising edge
    task automatic set_ab(input logic a, input logic b);
        enc_a = a;
        enc_b = b;
        repeat (HOLD) @(posedge clk);
        #1;
    endtask

    task automatic cw_detent();
        set_ab(1'b1, 1'b0);
        set_ab(1'b1, 1'b1);
        set_ab(1'b0, 1'b1);
        set_ab(1'b0, 1'b0);
    endtask

    task automatic ccw_detent();
        set_ab(1'b0, 1'b1);
        set_ab(1'b1, 1'b1);
        set_ab(1'b1, 1'b0);
        set_ab(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enc_a = 1'b0;
        enc_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int s0;
        rst_n = 1'b0; ena = 1'b1; enc_a = 1'b0; enc_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (value_s !== 8'd0 || step_s !== 1'b0 || dir_s !== 1'b0 || err_s !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: got value=%0d step=%b dir=%b err=%b expected 0 0 0 0",
                     value_s, step_s, dir_s, err_s);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 37; i++) cw_detent();
        checks++;
        if (value_s !== 8'd37) begin
            errors++;
            $display("FAIL reset_count37: got %0d expected 37", value_s);
        end
        // Partial sub-step in flight, then asynchronous reset between edges
        enc_a = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (value_s !== 8'd0 || step_s !== 1'b0 || err_s !== 1'b0 || dir_s !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got value=%0d step=%b err=%b dir=%b expected 0 0 0 0",
                     value_s, step_s, err_s, dir_s);
        end
        enc_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        s0 = step_cnt_s;
        cw_detent();
        checks++;
        if (value_s !== 8'd1 || step_cnt_s - s0 !== 1) begin
            errors++;
            $display("FAIL reset_restart: got value=%0d steps=%0d expected 1 1",
                     value_s, step_cnt_s - s0);
        end
    endtask

    task automatic test_clockwise();
        int s0;
        do_reset();
        s0 = step_cnt_s;
        for (int d = 0; d < 3; d++) begin
            set_ab(1'b1, 1'b0);
            set_ab(1'b1, 1'b1);
            set_ab(1'b0, 1'b1);
            enc_a = 1'b0;
            enc_b = 1'b0;
            for (int i = 1; i <= HOLD; i++) begin
                @(posedge clk);
                #1;
                checks++;
                if (step_s !== ((i == 7) ? 1'b1 : 1'b0)) begin
                    errors++;
                    $display("FAIL cw_latency: detent %0d edge %0d got step=%b expected %b",
                             d, i, step_s, (i == 7));
                end
                if (i == 7) begin
                    checks++;
                    if (dir_s !== 1'b1 || value_s !== 8'(d + 1)) begin
                        errors++;
                        $display("FAIL cw_pulse: got dir=%b value=%0d expected 1 %0d",
                                 dir_s, value_s, d + 1);
                    end
                end
            end
        end
        checks++;
        if (value_s !== 8'd3 || step_cnt_s - s0 !== 3) begin
            errors++;
            $display("FAIL cw_total: got value=%0d steps=%0d expected 3 3",
                     value_s, step_cnt_s - s0);
        end
    endtask

    task automatic test_saturate_wrap();
        int s0;
        int w0;
        do_reset();
        s0 = step_cnt_s;
        w0 = step_cnt_w;
        ccw_detent();
        checks++;
        if (value_s !== 8'd0 || dir_s !== 1'b0 || step_cnt_s - s0 !== 1) begin
            errors++;
            $display("FAIL sat_low: got value=%0d dir=%b steps=%0d expected 0 0 1",
                     value_s, dir_s, step_cnt_s - s0);
        end
        checks++;
        if (value_w !== 8'd255 || dir_w !== 1'b0 || step_cnt_w - w0 !== 1) begin
            errors++;
            $display("FAIL wrap_low: got value=%0d dir=%b steps=%0d expected 255 0 1",
                     value_w, dir_w, step_cnt_w - w0);
        end
        cw_detent();
        checks++;
        if (value_s !== 8'd1 || value_w !== 8'd0 || dir_s !== 1'b1) begin
            errors++;
            $display("FAIL sat_wrap_up: got sat=%0d wrap=%0d dir=%b expected 1 0 1",
                     value_s, value_w, dir_s);
        end
        do_reset();
        for (int i = 0; i < 255; i++) cw_detent();
        checks++;
        if (value_s !== 8'd255 || value_w !== 8'd255) begin
            errors++;
            $display("FAIL count_255: got sat=%0d wrap=%0d expected 255 255", value_s, value_w);
        end
        s0 = step_cnt_s;
        cw_detent();
        checks++;
        if (value_s !== 8'd255 || step_cnt_s - s0 !== 1 || dir_s !== 1'b1) begin
            errors++;
            $display("FAIL sat_high: got value=%0d steps=%0d dir=%b expected 255 1 1",
                     value_s, step_cnt_s - s0, dir_s);
        end
        checks++;
        if (value_w !== 8'd0) begin
            errors++;
            $display("FAIL wrap_high: got %0d expected 0", value_w);
        end
    endtask

    // A-pulse of given width immediately followed by B rising: if the pulse
    // was accepted, A falls and B rises together (illegal); otherwise B
    // alone gives a counter-clockwise detent.
    task automatic a_pulse_then_b(input int width);
        enc_a = 1'b1;
        repeat (width) @(posedge clk);
        #1;
        enc_a = 1'b0;
        enc_b = 1'b1;
        repeat (HOLD) @(posedge clk);
        #1;
    endtask

    task automatic test_debounce();
        int s0;
        int e0;
        do_reset();
        cw_detent();
        s0 = step_cnt_s;
        e0 = err_cnt_s;
        a_pulse_then_b(3);
        checks++;
        if (value_s !== 8'd0 || step_cnt_s - s0 !== 1 || err_cnt_s - e0 !== 0 || dir_s !== 1'b0) begin
            errors++;
            $display("FAIL debounce_short: got value=%0d steps=%0d errs=%0d dir=%b expected 0 1 0 0",
                     value_s, step_cnt_s - s0, err_cnt_s - e0, dir_s);
        end
        set_ab(1'b0, 1'b0);
        checks++;
        if (value_s !== 8'd1) begin
            errors++;
            $display("FAIL debounce_return: got %0d expected 1", value_s);
        end
        s0 = step_cnt_s;
        e0 = err_cnt_s;
        a_pulse_then_b(4);
        checks++;
        if (value_s !== 8'd1 || step_cnt_s - s0 !== 0 || err_cnt_s - e0 !== 1) begin
            errors++;
            $display("FAIL debounce_accept: got value=%0d steps=%0d errs=%0d expected 1 0 1",
                     value_s, step_cnt_s - s0, err_cnt_s - e0);
        end
        set_ab(1'b0, 1'b0);
        checks++;
        if (value_s !== 8'd2) begin
            errors++;
            $display("FAIL debounce_after: got %0d expected 2", value_s);
        end
    endtask

    task automatic test_illegal();
        int s0;
        int e0;
        do_reset();
        cw_detent();
        s0 = step_cnt_s;
        e0 = err_cnt_s;
        set_ab(1'b1, 1'b1);
        checks++;
        if (err_cnt_s - e0 !== 1 || step_cnt_s - s0 !== 0 || value_s !== 8'd1) begin
            errors++;
            $display("FAIL illegal_jump: got errs=%0d steps=%0d value=%0d expected 1 0 1",
                     err_cnt_s - e0, step_cnt_s - s0, value_s);
        end
        set_ab(1'b0, 1'b1);
        set_ab(1'b0, 1'b0);
        checks++;
        if (value_s !== 8'd2 || step_cnt_s - s0 !== 1 || err_cnt_s - e0 !== 1) begin
            errors++;
            $display("FAIL illegal_resync: got value=%0d steps=%0d errs=%0d expected 2 1 1",
                     value_s, step_cnt_s - s0, err_cnt_s - e0);
        end
    endtask

    task automatic test_enable();
        int s0;
        do_reset();
        cw_detent();
        ena = 1'b0;
        s0 = step_cnt_s;
        cw_detent();
        cw_detent();
        checks++;
        if (value_s !== 8'd1 || step_cnt_s - s0 !== 0) begin
            errors++;
            $display("FAIL ena_low_cw: got value=%0d steps=%0d expected 1 0",
                     value_s, step_cnt_s - s0);
        end
        ccw_detent();
        checks++;
        if (value_s !== 8'd1 || dir_s !== 1'b1 || step_cnt_s - s0 !== 0) begin
            errors++;
            $display("FAIL ena_low_ccw: got value=%0d dir=%b steps=%0d expected 1 1 0",
                     value_s, dir_s, step_cnt_s - s0);
        end
        ena = 1'b1;
        cw_detent();
        checks++;
        if (value_s !== 8'd2 || step_cnt_s - s0 !== 1) begin
            errors++;
            $display("FAIL ena_high: got value=%0d steps=%0d expected 2 1",
                     value_s, step_cnt_s - s0);
        end
    endtask

    task automatic test_pulse_shape();
        checks++;
        if (overlap_cnt !== 0) begin
            errors++;
            $display("FAIL step_err_overlap: got %0d cycles expected 0", overlap_cnt);
        end
        checks++;
        if (wide_err_cnt !== 0) begin
            errors++;
            $display("FAIL err_width: got %0d extra cycles expected 0", wide_err_cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_clockwise();
        test_saturate_wrap();
        test_debounce();
        test_illegal();
        test_enable();
        test_pulse_shape();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
